// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding and defaults.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int unsigned DEFAULT_DATA_BITS = 8;
    localparam logic [31:0] MIN_BIT_TIME      = 32'd4;

endpackage

// File: rtl/uart_rx_ctrl_async_timer.sv
// Bit timer: first sample half a bit after start, then one sample per bit time.
module uart_rx_ctrl_async_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        run,
    input  logic [31:0] bit_time,
    output logic        sample
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start) begin
            count <= (bit_time - 32'd1) >> 1;
        end else if (run) begin
            if (count == '0) begin
                count <= bit_time - 32'd1;
            end else begin
                count <= count - 32'd1;
            end
        end
    end

    // The start cycle itself never samples, whatever count was left over.
    assign sample = run && !start && (count == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronised rx, mid-bit sampling, optional parity, one-deep output.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          BIT_TIME,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int unsigned IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    state_t                 state, state_next;
    logic                   rx_meta, rx_s, rx_prev;
    logic                   tmr_start, tmr_start_next;
    logic                   sample;
    logic [DATA_BITS-1:0]   shreg, shreg_next;
    logic [IW-1:0]          bit_idx, bit_idx_next;
    logic                   par_bad, par_bad_next;
    logic [DATA_BITS-1:0]   rx_data_next;
    logic                   rx_valid_next;
    logic                   frame_err_next, parity_err_next, overrun_err_next;
    logic                   accept;

    uart_rx_ctrl_async_timer async_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tmr_start),
        .run      (busy),
        .bit_time (BIT_TIME),
        .sample   (sample)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            tmr_start   <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            par_bad     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_next;
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            rx_prev     <= rx_s;
            tmr_start   <= tmr_start_next;
            shreg       <= shreg_next;
            bit_idx     <= bit_idx_next;
            par_bad     <= par_bad_next;
            rx_data     <= rx_data_next;
            rx_valid    <= rx_valid_next;
            frame_err   <= frame_err_next;
            parity_err  <= parity_err_next;
            overrun_err <= overrun_err_next;
        end
    end

    always_comb begin
        state_next       = state;
        tmr_start_next   = 1'b0;
        shreg_next       = shreg;
        bit_idx_next     = bit_idx;
        par_bad_next     = par_bad;
        rx_data_next     = rx_data;
        rx_valid_next    = rx_valid;
        frame_err_next   = 1'b0;
        parity_err_next  = 1'b0;
        overrun_err_next = 1'b0;
        accept           = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s && rx_prev) begin
                    state_next     = START;
                    tmr_start_next = 1'b1;
                    par_bad_next   = 1'b0;
                end
            end
            START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_next = parity_en ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    par_bad_next = (^shreg) ^ rx_s ^ parity_odd;
                    state_next   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    state_next = IDLE;
                    if (!rx_s) begin
                        frame_err_next = 1'b1;
                    end else if (par_bad) begin
                        parity_err_next = 1'b1;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // An ack in the completion cycle frees the slot for the new byte.
        if (accept) begin
            if (!rx_valid || rx_ack) begin
                rx_data_next  = shreg;
                rx_valid_next = 1'b1;
            end else begin
                overrun_err_next = 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid_next = 1'b0;
        end
    end

endmodule
